pj_data_mem_banked: RTL

- Parametrised, banked successor to the core's single-bank synchronous data memory.
- Accepts one load or store request per cycle from the LSU over a valid/ready handshake.
- Stores are absorbed into an in-order store buffer and drained into BANKS_P synchronous SRAM banks. Loads forward from that buffer and return in order after a fixed RD_LAT_P cycles.
- Sits between pj_top_no_mem's data-memory interface and the SRAM macros. Exposes a commit observation port for the bench.

---
 rtl/pj_data_mem_banked.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pj_data_mem_banked.sv
// Banked synchronous data memory with an in-order store buffer and load forwarding.
// Loads return in order after RD_LAT_P cycles; drained stores are reported on the commit port.
module pj_data_mem_banked #(
    parameter int WIDTH_P      = 16,
    parameter int ADDR_WIDTH_P = 16,
    parameter int BANKS_P      = 2,
    parameter int RD_LAT_P     = 1,
    parameter int SB_DEPTH_P   = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_v_i,
    input  logic                    req_w_i,
    input  logic [ADDR_WIDTH_P-1:0] req_addr_i,
    input  logic [WIDTH_P-1:0]      req_data_i,
    output logic                    req_ready_o,
    output logic                    r_v_o,
    output logic [WIDTH_P-1:0]      r_data_o,
    output logic                    sb_empty_o,
    output logic                    commit_v_o,
    output logic [ADDR_WIDTH_P-1:0] commit_addr_o,
    output logic [WIDTH_P-1:0]      commit_data_o
);
    localparam int BANK_W = (BANKS_P > 1) ? $clog2(BANKS_P) : 0;
    localparam int BSEL_W = (BANKS_P > 1) ? BANK_W : 1;
    localparam int ROW_W  = ADDR_WIDTH_P - BANK_W;
    localparam int ROWS   = 2 ** ROW_W;
    localparam int PTR_W  = $clog2(SB_DEPTH_P);
    localparam int CNT_W  = PTR_W + 1;

    function automatic logic [BSEL_W-1:0] bank_of(input logic [ADDR_WIDTH_P-1:0] a);
        return BSEL_W'(a % ADDR_WIDTH_P'(BANKS_P));
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_WIDTH_P-1:0] a);
        return ROW_W'(a >> BANK_W);
    endfunction

    logic [ADDR_WIDTH_P-1:0] sb_addr_r [SB_DEPTH_P];
    logic [WIDTH_P-1:0]      sb_data_r [SB_DEPTH_P];
    logic [PTR_W-1:0]        head_r, tail_r;
    logic [CNT_W-1:0]        count_r, count_nxt_s;
    logic                    sb_empty_r;

    logic                    sb_full_s, ld_acc_s, st_acc_s, drain_s;
    logic [BSEL_W-1:0]       ld_bank_s, head_bank_s;
    logic [ROW_W-1:0]        ld_row_s, head_row_s;
    logic                    fwd_hit_s;
    logic [WIDTH_P-1:0]      fwd_data_s;
    logic [BANKS_P-1:0]      bank_we_s, bank_re_s;
    logic [WIDTH_P-1:0]      bank_rd_s [BANKS_P];

    logic                    ld_v1_r, fwd_hit1_r;
    logic [WIDTH_P-1:0]      fwd_data1_r, data1_s;
    logic [BSEL_W-1:0]       ld_bank1_r;

    logic                    commit_v_r;
    logic [ADDR_WIDTH_P-1:0] commit_addr_r;
    logic [WIDTH_P-1:0]      commit_data_r;

    // A load to the head's bank wins the port; the head store simply retries next cycle.
    assign sb_full_s   = (count_r == CNT_W'(SB_DEPTH_P));
    assign ld_acc_s    = req_v_i & ~req_w_i;
    assign st_acc_s    = req_v_i & req_w_i & ~sb_full_s;
    assign req_ready_o = ~(req_w_i & sb_full_s);
    assign ld_bank_s   = bank_of(req_addr_i);
    assign ld_row_s    = row_of(req_addr_i);
    assign head_bank_s = bank_of(sb_addr_r[head_r]);
    assign head_row_s  = row_of(sb_addr_r[head_r]);
    assign drain_s     = (count_r != '0) & ~(ld_acc_s & (ld_bank_s == head_bank_s));

    // Next occupancy of the store buffer.
    always_comb begin
        count_nxt_s = count_r;
        case ({st_acc_s, drain_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Forwarding search: walk oldest to youngest so the youngest match is the one kept.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = '0;
        for (int k = 0; k < SB_DEPTH_P; k++) begin
            if ((CNT_W'(k) < count_r) && (sb_addr_r[head_r + PTR_W'(k)] == req_addr_i)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = sb_data_r[head_r + PTR_W'(k)];
            end else begin
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Per-bank port enables.
    always_comb begin
        bank_we_s = '0;
        bank_re_s = '0;
        for (int b = 0; b < BANKS_P; b++) begin
            bank_we_s[b] = drain_s & (head_bank_s == BSEL_W'(b));
            bank_re_s[b] = ld_acc_s & (ld_bank_s == BSEL_W'(b));
        end
    end

    // Store buffer payload; only entries inside the head/count window are ever consumed.
    always_ff @(posedge clk_i) begin
        if (st_acc_s) begin
            sb_addr_r[tail_r] <= req_addr_i;
            sb_data_r[tail_r] <= req_data_i;
        end
    end

    // Store buffer pointers, occupancy and empty flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            sb_empty_r <= 1'b1;
        end else begin
            if (st_acc_s) tail_r <= tail_r + PTR_W'(1);
            if (drain_s)  head_r <= head_r + PTR_W'(1);
            count_r    <= count_nxt_s;
            sb_empty_r <= (count_nxt_s == '0);
        end
    end

    // Commit observation port, valid the cycle after the bank write.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            commit_v_r    <= 1'b0;
            commit_addr_r <= '0;
            commit_data_r <= '0;
        end else begin
            commit_v_r <= drain_s;
            if (drain_s) begin
                commit_addr_r <= sb_addr_r[head_r];
                commit_data_r <= sb_data_r[head_r];
            end
        end
    end

    for (genvar b = 0; b < BANKS_P; b++) begin : g_bank
        logic [WIDTH_P-1:0] mem_r [ROWS];
        logic [WIDTH_P-1:0] rd_r;

        // Array write port; contents survive reset.
        always_ff @(posedge clk_i) begin
            if (bank_we_s[b]) mem_r[head_row_s] <= sb_data_r[head_r];
        end

        // Synchronous read port.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                rd_r <= '0;
            end else if (bank_re_s[b]) begin
                rd_r <= mem_r[ld_row_s];
            end
        end

        assign bank_rd_s[b] = rd_r;
    end

    // First load stage: forwarding result captured at acceptance so both paths share latency.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ld_v1_r     <= 1'b0;
            fwd_hit1_r  <= 1'b0;
            fwd_data1_r <= '0;
            ld_bank1_r  <= '0;
        end else begin
            ld_v1_r <= ld_acc_s;
            if (ld_acc_s) begin
                fwd_hit1_r  <= fwd_hit_s;
                fwd_data1_r <= fwd_data_s;
                ld_bank1_r  <= ld_bank_s;
            end
        end
    end

    // Load data select, held at zero when no response is due.
    always_comb begin
        if (!ld_v1_r) begin
            data1_s = '0;
        end else if (fwd_hit1_r) begin
            data1_s = fwd_data1_r;
        end else begin
            data1_s = bank_rd_s[ld_bank1_r];
        end
    end

    if (RD_LAT_P == 2) begin : g_lat2
        logic               r_v_r;
        logic [WIDTH_P-1:0] r_data_r;

        // Extra response register for the two-cycle configuration.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                r_v_r    <= 1'b0;
                r_data_r <= '0;
            end else begin
                r_v_r    <= ld_v1_r;
                r_data_r <= data1_s;
            end
        end

        assign r_v_o    = r_v_r;
        assign r_data_o = r_data_r;
    end else begin : g_lat1
        assign r_v_o    = ld_v1_r;
        assign r_data_o = data1_s;
    end

    assign sb_empty_o    = sb_empty_r;
    assign commit_v_o    = commit_v_r;
    assign commit_addr_o = commit_addr_r;
    assign commit_data_o = commit_data_r;

endmodule
